// File: rtl/app_mult_err_monitor.sv
// -----------------------------------------------------------------------------
// app_mult_err_monitor
//
// Error-statistics monitor placed downstream of a registered approximate
// signed multiplier. It recomputes the exact product of the same operands and
// delays it through a two-stage pipeline. This pipeline mirrors the
// multiplier's en-gated registers, so the exact product lines up with the
// approximate `sum`. Over a window of 2^SAMPLES_LOG2 valid samples it
// accumulates the mismatch count, the saturating sum of |error| and the
// maximum |error|. The results are held for readout.
//
// Ports:
//   sys_clk     in   1               clock
//   sys_rst_n   in   1               asynchronous active-low reset
//   en          in   1               multiplier enable (same net)
//   start       in   1               pulse: clear statistics, start a window
//   A           in   WIDTH1          signed operand A
//   B           in   WIDTH2          signed operand B
//   sum         in   P               approximate product from the multiplier
//   busy        out  1               window in progress (RUN)
//   done        out  1               window complete, statistics frozen
//   sample_cnt  out  SAMPLES_LOG2+1  valid samples counted
//   err_cnt     out  SAMPLES_LOG2+1  samples with non-zero error
//   acc_err     out  ACC_W           saturating sum of |error|
//   max_err     out  P+1             largest |error|
// -----------------------------------------------------------------------------
module app_mult_err_monitor #(
    parameter int WIDTH1       = 8,
    parameter int WIDTH2       = 8,
    parameter int SAMPLES_LOG2 = 10,
    parameter int ACC_W        = 32
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       en,
    input  logic                       start,
    input  logic [WIDTH1-1:0]          A,
    input  logic [WIDTH2-1:0]          B,
    input  logic [WIDTH1+WIDTH2-1:0]   sum,
    output logic                       busy,
    output logic                       done,
    output logic [SAMPLES_LOG2:0]      sample_cnt,
    output logic [SAMPLES_LOG2:0]      err_cnt,
    output logic [ACC_W-1:0]           acc_err,
    output logic [WIDTH1+WIDTH2:0]     max_err
);

    localparam int P  = WIDTH1 + WIDTH2;
    localparam int E  = P + 1;
    localparam int CW = SAMPLES_LOG2 + 1;
    // Accumulator adder width: wide enough for either operand plus a carry.
    localparam int S  = ((ACC_W > E) ? ACC_W : E) + 1;

    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
    localparam logic [CW-1:0]    LAST_IDX = {1'b0, {SAMPLES_LOG2{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [P-1:0]   x1_q, x1_d;
    logic [P-1:0]   x2_q, x2_d;
    logic           v1_q, v1_d;
    logic           v2_q, v2_d;
    logic [CW-1:0]  sample_q, sample_d;
    logic [CW-1:0]  err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [E-1:0]   max_q, max_d;

    logic [P-1:0]   a_ext;
    logic [P-1:0]   b_ext;
    logic [P-1:0]   exact;
    logic [E-1:0]   diff;
    logic [E-1:0]   abs_err;
    logic           err_nz;
    logic [S-1:0]   acc_sum;
    logic [ACC_W-1:0] acc_sat;

    // Exact product and alignment pipeline. Sign-extending both operands to
    // P bits makes the truncated unsigned product equal the signed product,
    // because the result always fits in P bits.
    // NOTE: every variable assigned in always_comb gets a value on every path,
    // here by straight-line assignment, otherwise a latch is inferred.
    always_comb begin
        a_ext = {{WIDTH2{A[WIDTH1-1]}}, A};
        b_ext = {{WIDTH1{B[WIDTH2-1]}}, B};
        exact = a_ext * b_ext;
        x1_d  = en ? exact : '0;
        v1_d  = en;
        x2_d  = en ? x1_q : '0;
        v2_d  = en & v1_q;
    end

    // Error magnitude. The E-bit difference cannot overflow, and its
    // magnitude stays below 2^(E-1), so the negation is exact.
    always_comb begin
        diff    = {x2_q[P-1], x2_q} - {sum[P-1], sum};
        abs_err = diff[E-1] ? (~diff + E'(1)) : diff;
        err_nz  = |abs_err;
        acc_sum = S'(acc_q) + S'(abs_err);
        acc_sat = (acc_sum > S'(ACC_MAX)) ? ACC_MAX : acc_sum[ACC_W-1:0];
    end

    // Window control and statistics update.
    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        err_cnt_d = err_cnt_q;
        acc_d     = acc_q;
        max_d     = max_q;
        case (state_q)
            IDLE, DONE: begin
                // A sample valid in this same cycle is dropped: the clear wins.
                if (start) begin
                    state_d   = RUN;
                    sample_d  = '0;
                    err_cnt_d = '0;
                    acc_d     = '0;
                    max_d     = '0;
                end
            end
            RUN: begin
                if (v2_q) begin
                    sample_d  = sample_q + CW'(1);
                    err_cnt_d = err_cnt_q + CW'(err_nz);
                    acc_d     = acc_sat;
                    max_d     = (abs_err > max_q) ? abs_err : max_q;
                    if (sample_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from the values before the clock edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            x1_q      <= '0;
            x2_q      <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            sample_q  <= '0;
            err_cnt_q <= '0;
            acc_q     <= '0;
            max_q     <= '0;
        end else begin
            state_q   <= state_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            sample_q  <= sample_d;
            err_cnt_q <= err_cnt_d;
            acc_q     <= acc_d;
            max_q     <= max_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign sample_cnt = sample_q;
    assign err_cnt    = err_cnt_q;
    assign acc_err    = acc_q;
    assign max_err    = max_q;

endmodule

// File: doc/app_mult_err_monitor.md
# app_mult_err_monitor

Error-statistics monitor that sits directly downstream of the registered approximate signed multiplier (`app_mult_signed*`) in the CPD test setup. It receives the same operands and `en` as the multiplier, recomputes the exact product, and aligns it to the multiplier's two-cycle registered output. It then accumulates error statistics over a fixed window of valid samples: mismatch count, sum of absolute error, and maximum absolute error. Results are held on its outputs for readout.

## Interface
- `WIDTH1`, default 8: width of operand A (signed).
- `WIDTH2`, default 8: width of operand B (signed).
- `SAMPLES_LOG2`, default 10: the window length is 2^SAMPLES_LOG2 valid samples.
- `ACC_W`, default 32: width of the absolute-error accumulator.
- Product width P = WIDTH1+WIDTH2. Error width E = P+1.

Ports:
- `sys_clk`  in  1  clock.
- `sys_rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  the same `en` that drives the multiplier.
- `start`  in  1  single-cycle pulse; clears the statistics and starts a window.
- `A`  in  WIDTH1  signed operand, the same net as the multiplier's A.
- `B`  in  WIDTH2  signed operand, the same net as the multiplier's B.
- `sum`  in  P  approximate product from the multiplier's `sum` output.
- `busy`  out  1  high in state RUN.
- `done`  out  1  high in state DONE.
- `sample_cnt`  out  SAMPLES_LOG2+1  number of valid samples counted in the window.
- `err_cnt`  out  SAMPLES_LOG2+1  number of samples with non-zero error.
- `acc_err`  out  ACC_W  sum of |error|, saturating.
- `max_err`  out  E  largest |error| in the window.

## Operation
**Multiplier model.**
- At every clock edge with en=1, the multiplier captures A and B.
- At the next edge with en=1, it registers the product.
- Any edge with en=0 clears the multiplier's registers.
- A pair captured at edge k is therefore valid in `sum` after edge k+1 only if en=1 at both edge k and edge k+1.

**Alignment pipeline.**
- Stage 1, at each edge:
  - x1 <= en ? signed(A)*signed(B) : 0
  - v1 <= en
- Stage 2, at each edge:
  - x2 <= en ? x1 : 0
  - v2 <= en & v1
- During the cycle after edge k+1, x2 holds the exact product and `sum` holds the approximate product for the same pair. v2 marks the sample valid.

**Error computation.**
- d = sext(x2, E) - sext(sum, E).
- |d| is computed in E bits. This is exact for all operand combinations, including the most-negative by most-negative case.

**FSM states: IDLE, RUN, DONE.**
- IDLE → RUN on `start`. In the same edge, `sample_cnt`, `err_cnt`, `acc_err` and `max_err` are cleared to 0.
- RUN, on each edge where v2=1:
  - `sample_cnt` += 1
  - `err_cnt` += (|d| != 0)
  - `acc_err` = min(`acc_err` + |d|, 2^ACC_W - 1)
  - `max_err` = max(`max_err`, |d|)
- RUN → DONE at the edge that accumulates sample number 2^SAMPLES_LOG2. That sample is included in the statistics.
- `start` is ignored while in RUN.
- DONE: the statistics are frozen. `start` clears them and returns to RUN, as in IDLE.
- In IDLE and DONE, valid samples are not counted.

**Boundary conditions.**
- en=0 at any point: the pipeline inserts a bubble (v1 and v2 clear), so no sample is counted. Accumulation resumes after two consecutive en=1 edges.
- `start` arrives while v2=1 in IDLE: the clear takes priority and that sample is dropped. The first counted sample is the next valid one.
- `acc_err` saturates and stays at all-ones. The other counters cannot overflow by construction.
- Reset asserted mid-run: all state clears immediately (asynchronous). The FSM goes to IDLE and the pipeline is emptied.

## Timing
- Reset values: `busy`=0, `done`=0, `sample_cnt`=0, `err_cnt`=0, `acc_err`=0, `max_err`=0; x1, x2, v1 and v2 are 0; state is IDLE.
- Latency: a pair presented before edge k, with en=1 at edges k and k+1, is accumulated at edge k+2. Its effect is visible on the outputs during the cycle after edge k+2.
- `busy` goes high the cycle after `start`.
- `done` goes high the cycle after the final sample's edge and stays high until `start` or reset.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
Benches use SAMPLES_LOG2=2 unless noted.
1. **Exact pass-through.** Stub with `sum` = exact product and a 2-cycle register. Feed 4 pairs with en=1, then start → `done` high, `sample_cnt`=4, `err_cnt`=0, `acc_err`=0, `max_err`=0.
2. **Injected error.** Pairs (-3,5), (7,7), (-128,-128), (0,9); the stub returns exact-1, exact, exact+2, exact → `err_cnt`=2, `acc_err`=3, `max_err`=2. The exact product for (-128,-128) is checked as 16384.
3. **en gaps.** Toggle en 1,0,1,1,0,1,1,1 with distinct pairs → only pairs that see two consecutive en=1 edges are counted. `done` is delayed accordingly and `sample_cnt`=4.
4. **Saturation.** ACC_W=4, SAMPLES_LOG2=3, every error 3 → `acc_err`=15 is held, `max_err`=3, `err_cnt`=8.
5. **Restart and ignored start.** Pulse `start` mid-RUN → no effect. Pulse `start` in DONE → statistics clear the next cycle, `busy`=1, `done`=0.
6. **Reset mid-run.** Deassert `sys_rst_n` after 2 samples → all outputs 0 and state IDLE immediately. After release, a `start` plus 4 samples gives correct fresh statistics.
